// File: rtl/karat_seq.sv
// Sequential single-level Karatsuba multiplier: three partial products on one shared
// (WIDTH/2+1)-bit multiplier, then a combine step, with valid/ready on both sides.
`timescale 1ns/1ps

module karat_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   XY,
  output logic [2:0]           dbg_state_o
);
  localparam int H = WIDTH / 2;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("karat_seq: WIDTH must be even and at least 4");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid is held until out_ready is seen.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_MID  = 3'd3,
    S_COMB = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     xm_q, ym_q;
  logic                 neg_q;
  logic [WIDTH-1:0]     lo_q, hi_q;
  logic [WIDTH+1:0]     mid_q;
  logic [2*WIDTH-1:0]   xy_q;
  logic                 in_ready_q, out_valid_q;

  logic [WIDTH-1:0]     xm_d, ym_d;
  logic                 neg_d;
  logic [H:0]           xs, ys;
  logic [H:0]           mul_a, mul_b;
  logic [WIDTH+1:0]     mul_p;
  logic [WIDTH+1:0]     cross_d;
  logic [2*WIDTH-1:0]   p_d, xy_d;

  // Magnitudes are taken as unsigned WIDTH-bit values, so |-2^(WIDTH-1)| still fits.
  assign xm_d  = (signed_mode && X[WIDTH-1]) ? -X : X;
  assign ym_d  = (signed_mode && Y[WIDTH-1]) ? -Y : Y;
  assign neg_d = signed_mode & (X[WIDTH-1] ^ Y[WIDTH-1]);

  assign xs = {1'b0, xm_q[H-1:0]} + {1'b0, xm_q[WIDTH-1:H]};
  assign ys = {1'b0, ym_q[H-1:0]} + {1'b0, ym_q[WIDTH-1:H]};

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_LO: begin
        mul_a = {1'b0, xm_q[H-1:0]};
        mul_b = {1'b0, ym_q[H-1:0]};
      end
      S_HI: begin
        mul_a = {1'b0, xm_q[WIDTH-1:H]};
        mul_b = {1'b0, ym_q[WIDTH-1:H]};
      end
      S_MID: begin
        mul_a = xs;
        mul_b = ys;
      end
      default: ;
    endcase
  end

  assign mul_p = (WIDTH+2)'(mul_a) * (WIDTH+2)'(mul_b);

  // mid-lo-hi is the non-negative cross term; the exact product fits 2*WIDTH bits,
  // so summing {hi,lo} with the shifted cross term at that width loses nothing.
  assign cross_d = mid_q - {2'b00, lo_q} - {2'b00, hi_q};
  assign p_d     = {hi_q, lo_q} + ((2*WIDTH)'(cross_d) << H);
  assign xy_d    = neg_q ? -p_d : p_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      xy_q        <= '0;
      xm_q        <= '0;
      ym_q        <= '0;
      neg_q       <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      mid_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            xm_q       <= xm_d;
            ym_q       <= ym_d;
            neg_q      <= neg_d;
            in_ready_q <= 1'b0;
            state_q    <= S_LO;
          end
        end
        S_LO: begin
          lo_q    <= mul_p[WIDTH-1:0];
          state_q <= S_HI;
        end
        S_HI: begin
          hi_q    <= mul_p[WIDTH-1:0];
          state_q <= S_MID;
        end
        S_MID: begin
          mid_q   <= mul_p;
          state_q <= S_COMB;
        end
        S_COMB: begin
          xy_q        <= xy_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign XY          = xy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_karat_seq.sv
// Bench for karat_seq: directed 16-bit vectors with literal results, a plain-arithmetic
// product model feeding a scoreboard queue, and WIDTH=4/8/32 sweep instances.
`timescale 1ns/1ps

module tb_karat_seq;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        signed_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] xy;
  logic [2:0]  dbg_state;

  karat_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .X(x), .Y(y), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .XY(xy), .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: awaited event did not occur (t=%0t)", name, $time);
  endtask

  // Reference: exact integer product, truncated to 2*W bits.
  function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic m);
    logic signed [63:0] sa, sb, p;
    sa = m ? {{48{a[15]}}, a} : {48'd0, a};
    sb = m ? {{48{b[15]}}, b} : {48'd0, b};
    p  = sa * sb;
    return p[31:0];
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int   cyc = 0;
  int   last_acc = 0;
  logic have_last = 1'b0;
  logic b2b_on = 1'b0;
  int   n_acc = 0;
  int   n_hs = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      n_acc     <= n_hs;
      have_last <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model16(x, y, signed_mode));
        n_acc <= n_acc + 1;
        if (b2b_on && have_last) check("b2b_gap", 64'(cyc - last_acc), 64'd6);
        last_acc  <= cyc;
        have_last <= b2b_on;
      end else if (!b2b_on) begin
        have_last <= 1'b0;
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_hs <= n_hs + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) fail_now("unexpected_out_valid");
      else check("sb_xy", 64'(xy), 64'(exp_q[0]));
      check("busy_in_ready", 64'(in_ready), 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic txn(input logic [15:0] a, input logic [15:0] b, input logic m);
    int  n;
    bit  got;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail_now("wait_in_ready");
    x = a; y = b; signed_mode = m; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    x = 16'($urandom); y = 16'($urandom); signed_mode = 1'($urandom_range(0, 1));
    got = 1'b0;
    for (n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("wait_out_valid");
    else check("latency", 64'(n), 64'd4);
  endtask

  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic m, input logic [31:0] lit);
    txn(a, b, m);
    check(name, 64'(xy), 64'(lit));
    @(negedge clk);
  endtask

  // ---------------- parameter sweep instances ----------------
  for (genvar k = 0; k < 3; k++) begin : g_sw
    localparam int W = (k == 0) ? 4 : (k == 1) ? 8 : 32;
    localparam logic [63:0] ONES_SQ = (k == 0) ? 64'hE1 :
                                      (k == 1) ? 64'hFE01 : 64'hFFFFFFFE00000001;
    logic           srst = 1'b1;
    logic [W-1:0]   sx = '0;
    logic [W-1:0]   sy = '0;
    logic           ssm = 1'b0;
    logic           siv = 1'b0;
    logic           sir;
    logic           sov;
    logic           sor = 1'b1;
    logic [2*W-1:0] sxy;
    logic [2:0]     sst;
    logic           done = 1'b0;

    karat_seq #(.WIDTH(W)) u_sw (
      .clk(clk), .rst(srst), .in_valid(siv), .in_ready(sir),
      .X(sx), .Y(sy), .signed_mode(ssm), .out_valid(sov),
      .out_ready(sor), .XY(sxy), .dbg_state_o(sst)
    );

    function automatic logic [2*W-1:0] mdl(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic m);
      logic signed [127:0] sa, sb, p;
      sa = m ? {{(128-W){a[W-1]}}, a} : {{(128-W){1'b0}}, a};
      sb = m ? {{(128-W){b[W-1]}}, b} : {{(128-W){1'b0}}, b};
      p  = sa * sb;
      return p[2*W-1:0];
    endfunction

    task automatic sw_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
      bit got;
      int n;
      n = 0;
      while (!sir && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!sir) fail_now("sw_wait_in_ready");
      sx = a; sy = b; ssm = m; siv = 1'b1;
      @(negedge clk);
      siv = 1'b0;
      sx = W'($urandom); sy = W'($urandom);
      got = 1'b0;
      for (n = 1; n <= 12; n++) begin
        @(negedge clk);
        if (sov) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) fail_now("sw_wait_out_valid");
      else check($sformatf("sw%0d_xy", W), 64'(sxy), 64'(mdl(a, b, m)));
      @(negedge clk);
    endtask

    initial begin
      logic [W-1:0]   a, b;
      logic           m;
      logic [63:0]    ones_sq;
      int             n_sw;
      repeat (2) @(negedge clk);
      check($sformatf("sw%0d_rst_xy", W), 64'(sxy), 64'd0);
      check($sformatf("sw%0d_rst_rdy", W), 64'(sir), 64'd1);
      check($sformatf("sw%0d_rst_state", W), 64'(sst), 64'd0);
      srst = 1'b0;
      @(negedge clk);
      n_sw = (W == 4) ? 512 : 64;
      for (int i = 0; i < n_sw; i++) begin
        a = (W == 4) ? W'(i) : W'($urandom);
        b = (W == 4) ? W'(i >> 4) : W'($urandom);
        m = (W == 4) ? i[8] : 1'($urandom_range(0, 1));
        sw_txn(a, b, m);
      end
      sw_txn('1, '1, 1'b0);
      ones_sq = ONES_SQ;
      check($sformatf("sw%0d_ones_sq", W), 64'(sxy), ones_sq & ((64'd1 << (2*W-1)) * 2 - 1));
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int  n;
    int  hs0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_xy", 64'(xy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    directed("u_3x5",       16'd3,      16'd5,      1'b0, 32'd15);
    directed("u_255x255",   16'd255,    16'd255,    1'b0, 32'd65025);
    directed("u_1234x5678", 16'd1234,   16'd5678,   1'b0, 32'd7006652);
    directed("u_ffffxffff", 16'hFFFF,   16'hFFFF,   1'b0, 32'hFFFE0001);
    directed("s_m3x5",      16'hFFFD,   16'd5,      1'b1, 32'hFFFFFFF1);
    directed("s_m1xm1",     16'hFFFF,   16'hFFFF,   1'b1, 32'd1);
    directed("s_8000x8000", 16'h8000,   16'h8000,   1'b1, 32'h40000000);
    directed("s_8000x7fff", 16'h8000,   16'h7FFF,   1'b1, 32'hC0008000);
    directed("s_0xm7",      16'd0,      16'hFFF9,   1'b1, 32'd0);

    // Backpressure: result must sit still and a stray in_valid must be ignored.
    out_ready = 1'b0;
    txn(16'hFFFD, 16'd5, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_xy", 64'(xy), 64'hFFFFFFF1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      if (i == 4) begin
        x = 16'd7; y = 16'd7; signed_mode = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    hs0 = n_hs;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", 64'(out_valid), 64'd0);
    check("bp_hs_ready", 64'(in_ready), 64'd1);
    check("bp_hs_count", 64'(n_hs), 64'(hs0 + 1));
    @(negedge clk);
    check("bp_hs_once", 64'(n_hs), 64'(hs0 + 1));
    check("bp_idle_valid", 64'(out_valid), 64'd0);

    // Reset while the MID product is being formed.
    x = 16'd100; y = 16'd100; signed_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_xy", 64'(xy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    directed("post_rst_1234x5678", 16'd1234, 16'd5678, 1'b0, 32'd7006652);

    // Back-to-back with in_valid held high.
    b2b_on = 1'b1;
    x = 16'($urandom); y = 16'($urandom); signed_mode = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    n = 0;
    for (int g = 0; g < 9000 && n < 1000; g++) begin
      @(negedge clk);
      if (in_ready) begin
        @(negedge clk);
        n++;
        if (n < 1000) begin
          x = 16'($urandom); y = 16'($urandom); signed_mode = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    b2b_on = 1'b0;
    check("b2b_count", 64'(n), 64'd1000);
    for (int g = 0; g < 20 && exp_q.size() != 0; g++) @(negedge clk);
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("hs_vs_acc", 64'(n_hs), 64'(n_acc));

    for (int g = 0; g < 20000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done); g++)
      @(negedge clk);
    if (!(g_sw[0].done && g_sw[1].done && g_sw[2].done)) fail_now("sweep_done");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/karat_seq.md
# karat_seq

Parametrised, sequential, single-level Karatsuba multiplier; the successor to the combinational 16×16 `karat` block. It computes the three Karatsuba partial products one per cycle on a single shared (WIDTH/2+1)-bit multiplier, then combines them. It supports unsigned and two's-complement signed operands, selected per transaction. Input and output use valid/ready handshakes so the block can sit between pipelined datapath stages.

## Interface
- WIDTH, 16, operand width; must be even and ≥ 4; an odd WIDTH is an elaboration error. H = WIDTH/2.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- X  input  WIDTH  multiplicand.
- Y  input  WIDTH  multiplier.
- signed_mode  input  1  1 = treat X and Y as two's complement; 0 = unsigned. Sampled with X and Y.
- out_valid  output  1  XY holds a valid result.
- out_ready  input  1  consumer accepts the result.
- XY  output  2*WIDTH  product.

## Operation
- **Accept:** on a rising edge where in_valid && in_ready, register the operands and sign.
  - Unsigned (signed_mode=0): magnitudes are X and Y.
  - Signed (signed_mode=1): magnitudes are |X| and |Y|, each WIDTH bits unsigned; |−2^(WIDTH−1)| = 2^(WIDTH−1) fits.
  - Record neg = signed_mode & (X[MSB] ^ Y[MSB]).
- **Split:** xh/xl and yh/yl are the upper and lower H bits of each magnitude.
- **FSM states:** IDLE → LO → HI → MID → COMB → DONE.
  - IDLE: in_ready=1. An accept moves to LO.
  - LO: register lo = xl*yl (2H bits). Move to HI.
  - HI: register hi = xh*yh (2H bits). Move to MID.
  - MID: register mid = (xl+xh)*(yl+yh). The sums are H+1 bits; the product is 2H+2 bits. Move to COMB.
  - COMB: form p = (hi << WIDTH) + ((mid − lo − hi) << H) + lo at 2*WIDTH+2 bits. The result is exact and fits in 2*WIDTH bits. If neg, register XY = −p (two's complement, 2*WIDTH bits); otherwise register XY = p. Set out_valid. Move to DONE.
  - DONE: hold XY and out_valid. When out_ready=1, clear out_valid and move to IDLE.
- LO, HI and MID all use the same single (H+1)×(H+1) multiplier instance, with multiplexed operands zero-extended to H+1 bits.
- in_valid is ignored outside IDLE. X, Y and signed_mode may change freely after the accept edge.
- A zero product with neg=1 yields XY=0. No negative zero exists.
- XY is updated only on the COMB edge and held otherwise, including through IDLE.

## Timing
- **Reset values:** state=IDLE, in_ready=1, out_valid=0, XY=0, internal product registers 0.
- **Reset mid-operation:** asserting rst in any state immediately (asynchronously) returns the outputs to their reset values. The in-flight transaction is discarded and no result is produced.
- **Latency:** out_valid rises after the 4th rising edge following the accept edge.
- **Throughput:** at most one transaction per 6 cycles: accept, 4 compute edges, then output handshake. in_ready rises after the handshake edge, so the earliest next accept is the following edge.
- **Backpressure:** while out_valid && !out_ready, XY and out_valid are stable for any number of cycles, and in_ready stays 0.
- **Same-edge events:** out_ready together with out_valid on an edge completes the handshake on that edge. in_valid asserted in DONE is not accepted.
- out_ready while out_valid=0 has no effect.

## Test plan
- **Unsigned, WIDTH=16, out_ready=1:**
  - 3×5 → XY=15.
  - 255×255 → 65025.
  - 1234×5678 → 7006652.
  - 0xFFFF×0xFFFF → 0xFFFE0001.
  - In every case out_valid rises exactly 4 edges after the accept edge.
- **Signed, WIDTH=16:**
  - −3×5 → 0xFFFFFFF1.
  - −1×−1 → 1.
  - 0x8000×0x8000 → 0x40000000.
  - 0x8000×0x7FFF → 0xC0008000.
  - 0×−7 → 0.
- **Backpressure:** hold out_ready=0 for 10 cycles after out_valid → XY and out_valid stable, in_ready=0, and an in_valid pulse is ignored. Then out_ready=1 → exactly one handshake, after which in_ready=1.
- **Back-to-back:** in_valid held high with out_ready=1 → accepts every 6 cycles, in order. Results match a reference model over 1000 random unsigned and signed pairs.
- **Reset mid-operation:** assert rst in MID → out_valid=0, XY=0 and in_ready=1 immediately. After release, the next transaction 1234×5678 → 7006652 with correct latency.
- **Parameter sweep:** WIDTH=4, 8 and 32 instances.
  - WIDTH=4: exhaustive unsigned and signed pairs.
  - WIDTH=32: 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE00000001.
